// File: rtl/rv32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rv32_mem_arbiter (with package rv32_types)
// Purpose  : Round-robin arbiter that shares one memory port between the
//            instruction-fetch requester (F) and the memory-stage requester
//            (D). The winning request is latched and driven downstream until
//            the memory answers. The done strobe is routed back to the winner.
//            A watchdog flags a memory that never responds.
// Ports    : clk, resetn        clock, synchronous active-low reset
//            fetch_request/done port F request in, completion strobe out
//            data_request/done  port D request in, completion strobe out
//            mem_request        registered request to the shared memory
//            mem_done/mem_rdata memory completion and read data
//            rdata              mem_rdata passed through to both ports
//            grant              00 idle, 01 F, 10 D
//            timeout_err        sticky watchdog flag
// Revision : 1.0 - initial release
// ============================================================================

package rv32_types;
  typedef enum logic [1:0] {
    MEM_NOP   = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_t;

  typedef struct packed {
    mem_op_t     op;
    logic [31:0] addr;
    logic [31:0] data;
  } memory_request_t;
endpackage

module rv32_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  rv32_types::memory_request_t fetch_request,
  output logic                        fetch_done,
  input  rv32_types::memory_request_t data_request,
  output logic                        data_done,
  output rv32_types::memory_request_t mem_request,
  input  logic                        mem_done,
  input  logic [31:0]                 mem_rdata,
  output logic [31:0]                 rdata,
  output logic [1:0]                  grant,
  output logic                        timeout_err
);
  import rv32_types::*;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_F = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam logic             OWNER_F = 1'b0;
  localparam logic             OWNER_D = 1'b1;
  localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic             WDOG_EN = (TIMEOUT_CYCLES != 0);

  state_t            state_q, state_d;
  memory_request_t   lreq_q, lreq_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic f_pend, d_pend;
  assign f_pend = (fetch_request.op != MEM_NOP);
  assign d_pend = (data_request.op  != MEM_NOP);

  // Memory request is purely the latched copy: no input-to-output path.
  assign mem_request = lreq_q;
  assign rdata       = mem_rdata;
  assign timeout_err = err_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      lreq_q  <= '{op: MEM_NOP, addr: 32'd0, data: 32'd0};
      last_q  <= OWNER_F;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lreq_q  <= lreq_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lreq_d     = lreq_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    grant      = 2'b00;
    fetch_done = 1'b0;
    data_done  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // On contention the port that was not served last wins.
        if (f_pend && (!d_pend || (last_q == OWNER_D))) begin
          state_d = GNT_F;
          lreq_d  = fetch_request;
        end else if (d_pend) begin
          state_d = GNT_D;
          lreq_d  = data_request;
        end
      end

      GNT_F: begin
        grant      = 2'b01;
        fetch_done = mem_done;
        if (mem_done) begin
          last_d = OWNER_F;
          cnt_d  = '0;
          // F still shows the completed request here, so only D can chain.
          if (d_pend) begin
            state_d = GNT_D;
            lreq_d  = data_request;
          end else begin
            state_d   = IDLE;
            lreq_d.op = MEM_NOP;
          end
        end else if (cnt_q != TO_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      GNT_D: begin
        grant     = 2'b10;
        data_done = mem_done;
        if (mem_done) begin
          last_d = OWNER_D;
          cnt_d  = '0;
          if (f_pend) begin
            state_d = GNT_F;
            lreq_d  = fetch_request;
          end else begin
            state_d   = IDLE;
            lreq_d.op = MEM_NOP;
          end
        end else if (cnt_q != TO_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        lreq_d.op = MEM_NOP;
      end
    endcase

    // Flag sets on the edge where the counter lands on the limit.
    err_d = err_q | (WDOG_EN && (cnt_d == TO_MAX));
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32_mem_arbiter
// Purpose  : Directed self-checking bench for rv32_mem_arbiter
//            (watchdog limit of 4 cycles).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32_mem_arbiter;
  import rv32_types::*;

  logic            clk;
  logic            resetn;
  memory_request_t fetch_request;
  logic            fetch_done;
  memory_request_t data_request;
  logic            data_done;
  memory_request_t mem_request;
  logic            mem_done;
  logic [31:0]     mem_rdata;
  logic [31:0]     rdata;
  logic [1:0]      grant;
  logic            timeout_err;

  int n_checks;
  int n_fail;

  rv32_mem_arbiter #(
    .TIMEOUT_CYCLES(4),
    .CNT_W         (8)
  ) u_dut (
    .clk          (clk),
    .resetn       (resetn),
    .fetch_request(fetch_request),
    .fetch_done   (fetch_done),
    .data_request (data_request),
    .data_done    (data_done),
    .mem_request  (mem_request),
    .mem_done     (mem_done),
    .mem_rdata    (mem_rdata),
    .rdata        (rdata),
    .grant        (grant),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic memory_request_t mk(mem_op_t op, logic [31:0] addr, logic [31:0] data);
    memory_request_t r;
    r.op   = op;
    r.addr = addr;
    r.data = data;
    return r;
  endfunction

  task automatic chk_eq(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then driven at posedge+1, checks at posedge+2.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  memory_request_t exp_req;

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    resetn        = 1'b0;
    fetch_request = mk(MEM_NOP, 32'd0, 32'd0);
    data_request  = mk(MEM_NOP, 32'd0, 32'd0);
    mem_done      = 1'b0;
    mem_rdata     = 32'd0;

    // ---------------- reset state ----------------
    do_reset();
    settle();
    chk_eq("rst_grant", 66'(grant), 66'(2'b00));
    chk_eq("rst_mem_op", 66'(mem_request.op), 66'(MEM_NOP));
    chk_eq("rst_timeout", 66'(timeout_err), 66'(1'b0));

    // ---------------- single F load ----------------
    fetch_request = mk(MEM_LOAD, 32'h100, 32'h0);
    settle();
    chk_eq("f1_idle_grant", 66'(grant), 66'(2'b00));
    tick();
    settle();
    chk_eq("f1_grant", 66'(grant), 66'(2'b01));
    chk_eq("f1_addr", 66'(mem_request.addr), 66'(32'h100));
    chk_eq("f1_op", 66'(mem_request.op), 66'(MEM_LOAD));
    mem_done  = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    settle();
    chk_eq("f1_fdone", 66'(fetch_done), 66'(1'b1));
    chk_eq("f1_ddone", 66'(data_done), 66'(1'b0));
    chk_eq("f1_rdata", 66'(rdata), 66'(32'hDEADBEEF));
    tick();
    fetch_request = mk(MEM_NOP, 32'd0, 32'd0);
    mem_done      = 1'b0;
    settle();
    chk_eq("f1_back_idle", 66'(grant), 66'(2'b00));
    chk_eq("f1_idle_op", 66'(mem_request.op), 66'(MEM_NOP));

    // ---------------- simultaneous after reset: D first, then F, no bubble ----------------
    do_reset();
    fetch_request = mk(MEM_LOAD, 32'h200, 32'h0);
    data_request  = mk(MEM_STORE, 32'h300, 32'h55);
    tick();
    settle();
    chk_eq("both_first_D", 66'(grant), 66'(2'b10));
    chk_eq("both_D_req", 66'(mem_request), 66'(mk(MEM_STORE, 32'h300, 32'h55)));
    mem_done = 1'b1;
    settle();
    chk_eq("both_ddone", 66'(data_done), 66'(1'b1));
    chk_eq("both_fdone0", 66'(fetch_done), 66'(1'b0));
    tick();
    data_request = mk(MEM_NOP, 32'd0, 32'd0);
    mem_done     = 1'b0;
    settle();
    chk_eq("both_then_F", 66'(grant), 66'(2'b01));
    chk_eq("both_F_addr", 66'(mem_request.addr), 66'(32'h200));
    mem_done = 1'b1;
    settle();
    chk_eq("both_fdone", 66'(fetch_done), 66'(1'b1));
    tick();
    fetch_request = mk(MEM_NOP, 32'd0, 32'd0);
    mem_done      = 1'b0;
    settle();
    chk_eq("both_idle", 66'(grant), 66'(2'b00));

    // ---------------- continuous contention: strict alternation ----------------
    // last owner is F, so D wins first, then F, D, F, D.
    fetch_request = mk(MEM_LOAD, 32'h400, 32'h0);
    data_request  = mk(MEM_LOAD, 32'h500, 32'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      settle();
      chk_eq($sformatf("alt_grant%0d", i), 66'(grant), 66'((i % 2 == 0) ? 2'b10 : 2'b01));
      chk_eq($sformatf("alt_addr%0d", i), 66'(mem_request.addr),
             66'((i % 2 == 0) ? 32'h500 : 32'h400));
      mem_done = 1'b1;
      settle();
      chk_eq($sformatf("alt_done%0d", i), 66'({fetch_done, data_done}),
             66'((i % 2 == 0) ? 2'b01 : 2'b10));
      if (i == 4) begin
        fetch_request = mk(MEM_NOP, 32'd0, 32'd0);
        data_request  = mk(MEM_NOP, 32'd0, 32'd0);
      end
      tick();
      mem_done = 1'b0;
    end
    settle();
    chk_eq("alt_idle", 66'(grant), 66'(2'b00));

    // ---------------- stall 5 cycles + watchdog ----------------
    do_reset();
    fetch_request = mk(MEM_LOAD, 32'h600, 32'h0);
    exp_req       = mk(MEM_LOAD, 32'h600, 32'h0);
    tick();
    // requester changes its inputs mid-grant; latched copy must not follow
    fetch_request = mk(MEM_STORE, 32'h7FF, 32'h1234);
    for (int i = 1; i <= 5; i++) begin
      settle();
      chk_eq($sformatf("stall_req%0d", i), 66'(mem_request), 66'(exp_req));
      chk_eq($sformatf("stall_done%0d", i), 66'({fetch_done, data_done}), 66'(2'b00));
      chk_eq($sformatf("stall_err%0d", i), 66'(timeout_err), 66'((i >= 5) ? 1'b1 : 1'b0));
      tick();
    end
    mem_done = 1'b1;
    settle();
    chk_eq("stall_req6", 66'(mem_request), 66'(exp_req));
    chk_eq("stall_done6", 66'({fetch_done, data_done}), 66'(2'b10));
    tick();
    mem_done = 1'b0;
    settle();
    // finishing port's inputs in the done cycle are ignored
    chk_eq("stall_bubble", 66'(grant), 66'(2'b00));
    chk_eq("stall_no_redone", 66'(fetch_done), 66'(1'b0));
    chk_eq("err_sticky", 66'(timeout_err), 66'(1'b1));
    tick();
    settle();
    chk_eq("f_rearb", 66'(grant), 66'(2'b01));
    chk_eq("f_rearb_req", 66'(mem_request), 66'(mk(MEM_STORE, 32'h7FF, 32'h1234)));
    fetch_request = mk(MEM_NOP, 32'd0, 32'd0);
    do_reset();
    settle();
    chk_eq("err_cleared", 66'(timeout_err), 66'(1'b0));

    // ---------------- reset mid-grant, mem_done right after ----------------
    data_request = mk(MEM_STORE, 32'h800, 32'h99);
    tick();
    settle();
    chk_eq("mid_grant_D", 66'(grant), 66'(2'b10));
    resetn = 1'b0;
    tick();
    resetn       = 1'b1;
    data_request = mk(MEM_NOP, 32'd0, 32'd0);
    mem_done     = 1'b1;
    settle();
    chk_eq("mid_rst_grant", 66'(grant), 66'(2'b00));
    chk_eq("mid_rst_dones", 66'({fetch_done, data_done}), 66'(2'b00));
    chk_eq("mid_rst_op", 66'(mem_request.op), 66'(MEM_NOP));
    tick();
    mem_done = 1'b0;
    settle();
    chk_eq("mid_rst_stay_idle", 66'(grant), 66'(2'b00));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
